alu_issue_ctrl: RTL and testbench

- Issuing side of the 16-bit ALU operand/opcode/result interface.
- Accepts external 16-bit instructions over a valid/ready handshake and reads two operands from an internal 8x16 register file.
- Drives the ALU's a/b/opcode inputs from registers, captures the ALU's 32-bit result, writes the low half back to the register file, and presents the full result plus flags on a valid/ready result port.

---
 rtl/alu_issue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue controller for a 16-bit ALU with an 8x16 register file.
// Accepts instructions over valid/ready, drives registered ALU operands for
// one EXEC cycle, captures the 32-bit result, writes the low half back and
// presents result plus flags on a valid/ready result port.
// Optional retire/illegal statistics counters: define ALU_ISSUE_STATS_EN.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and its payload until that edge, and
// ready never depends combinationally on valid (both ready/valid are registers).
module alu_issue_ctrl #(
    parameter int               DW       = 16,
    parameter int               RW       = 32,
    parameter logic [DW-1:0]    RF_RESET = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [RW-1:0] alu_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic [2:0]    res_rd,
    output logic          res_zero,
    output logic          res_carry,
    output logic          res_err
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]   retired_cnt,
    output logic [15:0]   illegal_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b111;

    state_t        state_q;
    logic          instr_ready_q;
    logic [2:0]    op_q;
    logic [2:0]    rd_q;
    logic [9:0]    imm_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic [2:0]    alu_op_q;
    logic          res_valid_q;
    logic [RW-1:0] res_data_q;
    logic [2:0]    res_rd_q;
    logic          res_zero_q;
    logic          res_carry_q;
    logic          res_err_q;
    logic [DW-1:0] rf_q [8];
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0]   retired_cnt_q;
    logic [15:0]   illegal_cnt_q;
`endif

    logic [RW-1:0] res_data_d;
    logic          res_zero_d;
    logic          res_carry_d;
    logic          res_err_d;
    logic          rf_we_d;

    // Result and flags that EXEC will capture, selected by the latched opcode.
    always_comb begin
        res_data_d  = '0;
        res_carry_d = 1'b0;
        res_err_d   = 1'b0;
        rf_we_d     = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_data_d  = alu_out;
                res_carry_d = alu_out[16];
                rf_we_d     = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                res_data_d = alu_out;
                rf_we_d    = 1'b1;
            end
            OP_LDI: begin
                res_data_d = {{(RW-10){1'b0}}, imm_q};
                rf_we_d    = 1'b1;
            end
            default: begin
                res_err_d = 1'b1;
            end
        endcase
        res_zero_d = (res_data_d[DW-1:0] == '0);
    end

    // Issue FSM: accept, execute for one cycle, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            instr_ready_q <= 1'b1;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_zero_q    <= 1'b0;
            res_carry_q   <= 1'b0;
            res_err_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= RF_RESET;
            end
`ifdef ALU_ISSUE_STATS_EN
            retired_cnt_q <= '0;
            illegal_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid && instr_ready_q) begin
                        op_q          <= instr[15:13];
                        rd_q          <= instr[12:10];
                        imm_q         <= instr[9:0];
                        instr_ready_q <= 1'b0;
                        state_q       <= EXEC;
                        // Only real ALU ops touch the ALU ports; LDI/illegal leave them alone.
                        if (instr[15:13] <= OP_XOR) begin
                            alu_a_q  <= rf_q[instr[9:7]];
                            alu_b_q  <= rf_q[instr[6:4]];
                            alu_op_q <= instr[15:13];
                        end
                    end
                end
                EXEC: begin
                    res_data_q  <= res_data_d;
                    res_rd_q    <= rd_q;
                    res_zero_q  <= res_zero_d;
                    res_carry_q <= res_carry_d;
                    res_err_q   <= res_err_d;
                    res_valid_q <= 1'b1;
                    if (rf_we_d) begin
                        rf_q[rd_q] <= res_data_d[DW-1:0];
                    end
                    state_q <= WB;
                end
                WB: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        instr_ready_q <= 1'b1;
                        state_q       <= IDLE;
`ifdef ALU_ISSUE_STATS_EN
                        retired_cnt_q <= retired_cnt_q + 16'd1;
                        if (res_err_q) begin
                            illegal_cnt_q <= illegal_cnt_q + 16'd1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_zero    = res_zero_q;
    assign res_carry   = res_carry_q;
    assign res_err     = res_err_q;
`ifdef ALU_ISSUE_STATS_EN
    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: table of directed vectors, hand-written reset
// and back-to-back sequences, then randomized instructions against a model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_rd;
    logic        res_zero;
    logic        res_carry;
    logic        res_err;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] retired_cnt;
    logic [15:0] illegal_cnt;
`endif

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_zero(res_zero), .res_carry(res_carry), .res_err(res_err)
`ifdef ALU_ISSUE_STATS_EN
        , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: pure combinational function of its inputs.
    always_comb begin
        case (alu_op)
            3'b000:  alu_out = {16'h0, alu_a} + {16'h0, alu_b};
            3'b001:  alu_out = {16'h0, alu_a} - {16'h0, alu_b};
            3'b010:  alu_out = {16'h0, alu_a & alu_b};
            3'b011:  alu_out = {16'h0, alu_a | alu_b};
            3'b100:  alu_out = {16'h0, alu_a ^ alu_b};
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // reference model: architectural register file and retire counters
    logic [15:0] rf_m [8];
    int          retired_m = 0;
    int          illegal_m = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;
        retired_m = 0;
        illegal_m = 0;
    endtask

    task automatic predict(input logic [15:0] ins, output logic [31:0] d,
                           output logic z, output logic c, output logic e);
        int unsigned a, b, r;
        a = rf_m[ins[9:7]];
        b = rf_m[ins[6:4]];
        e = 1'b0;
        c = 1'b0;
        case (ins[15:13])
            3'd0: begin r = a + b; c = (r >= 32'h1_0000); end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd7: r = ins[9:0];
            default: begin r = 0; e = 1'b1; end
        endcase
        d = r;
        z = (r % 65536 == 0);
        if (!e) rf_m[ins[12:10]] = r % 65536;
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        logic [2:0] o, d, s1, s2;
        o = op[2:0]; d = rd[2:0]; s1 = rs1[2:0]; s2 = rs2[2:0];
        return {o, d, s1, s2, 4'b0000};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input int imm);
        logic [2:0] d;
        logic [9:0] im;
        d = rd[2:0]; im = imm[9:0];
        return {3'b111, d, im};
    endfunction

    logic [15:0] ex_a, ex_b;
    logic [2:0]  ex_op;

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_timeout", {31'b0, instr_ready}, 32'd1);
    endtask

    // driver: issue one instruction, check result, hold it for 'hold' cycles, retire
    task automatic do_instr(input logic [15:0] ins, input int hold, input logic [31:0] ed,
                            input logic ez, input logic ec, input logic ee);
        int n;
        wait_ready();
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
        ex_a = alu_a; ex_b = alu_b; ex_op = alu_op;
        chk("exec_ready", {31'b0, instr_ready}, 32'd0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("res_latency", n, 32'd1);
        chk("res_data", res_data, ed);
        chk("res_zero", {31'b0, res_zero}, {31'b0, ez});
        chk("res_carry", {31'b0, res_carry}, {31'b0, ec});
        chk("res_err", {31'b0, res_err}, {31'b0, ee});
        chk("res_rd", {29'b0, res_rd}, {29'b0, ins[12:10]});
        for (int h = 0; h < hold; h++) begin
            instr_valid = 1'b1;
            instr = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, res_valid}, 32'd1);
            chk("hold_data", res_data, ed);
            chk("hold_ready", {31'b0, instr_ready}, 32'd0);
        end
        instr_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        retired_m++;
        if (ee) illegal_m++;
        chk("res_valid_drop", {31'b0, res_valid}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] ins;
        int          hold;
        logic [31:0] d;
        logic        z, c, e;
        logic        chk_alu;
        logic [15:0] a, b;
        logic [2:0]  op;
    } vec_t;

    vec_t        tbl [17];
    logic [15:0] b2b_prog [4];
    int          acc_cyc [4];
    logic [31:0] md;
    logic        mz, mc, me;

    initial begin
        tbl[0]  = '{ldi(1, 10'h3FF), 0, 32'h0000_03FF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[1]  = '{ldi(2, 10'h001), 0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[2]  = '{enc(0, 3, 1, 2), 0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b1, 16'h03FF, 16'h0001, 3'd0};
        tbl[3]  = '{enc(3, 3, 3, 3), 0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[4]  = '{ldi(1, 0),       0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[5]  = '{ldi(2, 1),       0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[6]  = '{enc(1, 4, 1, 2), 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001, 3'd1};
        tbl[7]  = '{enc(3, 4, 4, 4), 0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[8]  = '{enc(4, 5, 3, 3), 5, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[9]  = '{enc(6, 3, 0, 0), 0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0400, 16'h0400, 3'd4};
        tbl[10] = '{enc(3, 3, 3, 3), 0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[11] = '{enc(0, 6, 4, 2), 0, 32'h0001_0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[12] = '{ldi(7, 10'h3FF), 0, 32'h0000_03FF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'd0};
        tbl[13] = '{enc(0, 7, 7, 7), 0, 32'h0000_07FE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[14] = '{enc(3, 7, 7, 7), 0, 32'h0000_07FE, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[15] = '{enc(5, 0, 1, 1), 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0};
        tbl[16] = '{enc(3, 0, 0, 0), 0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0};
        b2b_prog[0] = ldi(1, 10'h3FF);
        b2b_prog[1] = ldi(2, 10'h002);
        b2b_prog[2] = enc(0, 3, 1, 2);
        b2b_prog[3] = enc(1, 4, 2, 1);

        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; res_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_flags", {28'b0, res_rd, res_zero}, 32'd0);
        chk("rst_carry_err", {30'b0, res_carry, res_err}, 32'd0);
        chk("rst_alu", {alu_op, alu_a, alu_b[12:0]}, 32'd0);

        // directed table
        for (int i = 0; i < 17; i++) begin
            predict(tbl[i].ins, md, mz, mc, me);
            do_instr(tbl[i].ins, tbl[i].hold, tbl[i].d, tbl[i].z, tbl[i].c, tbl[i].e);
            if (tbl[i].chk_alu) begin
                chk("exec_alu_a", {16'b0, ex_a}, {16'b0, tbl[i].a});
                chk("exec_alu_b", {16'b0, ex_b}, {16'b0, tbl[i].b});
                chk("exec_alu_op", {29'b0, ex_op}, {29'b0, tbl[i].op});
            end
        end
`ifdef ALU_ISSUE_STATS_EN
        chk("tbl_retired_cnt", {16'b0, retired_cnt}, 32'd17);
        chk("tbl_illegal_cnt", {16'b0, illegal_cnt}, 32'd2);
`endif

        // reset during EXEC of ADD r6: no write, everything back to reset values
        wait_ready();
        instr = enc(0, 6, 7, 7);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("exec_rst_ready", {31'b0, instr_ready}, 32'd1);
        chk("exec_rst_valid", {31'b0, res_valid}, 32'd0);
        chk("exec_rst_data", res_data, 32'd0);
        chk("exec_rst_alu_a", {16'b0, alu_a}, 32'd0);
        chk("exec_rst_alu_op", {29'b0, alu_op}, 32'd0);
        do_instr(enc(3, 6, 6, 6), 0, 32'h0, 1'b1, 1'b0, 1'b0);
        do_instr(enc(3, 7, 7, 7), 0, 32'h0, 1'b1, 1'b0, 1'b0);
        rf_m[6] = 16'h0; rf_m[7] = 16'h0;
        retired_m = 2;

        // reset during WB: pending result dropped
        wait_ready();
        instr = ldi(2, 5);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("wb_valid_pre_rst", {31'b0, res_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("wb_rst_valid", {31'b0, res_valid}, 32'd0);
        chk("wb_rst_data", res_data, 32'd0);
        chk("wb_rst_ready", {31'b0, instr_ready}, 32'd1);
        do_instr(enc(3, 2, 2, 2), 0, 32'h0, 1'b1, 1'b0, 1'b0);

        // back-to-back: instr_valid held high, res_ready held high
        res_ready = 1'b1;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr = b2b_prog[k];
            wait_ready();
            acc_cyc[k] = cyc;
            predict(b2b_prog[k], md, mz, mc, me);
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("b2b_valid", {31'b0, res_valid}, 32'd1);
            chk("b2b_data", res_data, md);
            chk("b2b_carry", {31'b0, res_carry}, {31'b0, mc});
            retired_m++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        res_ready = 1'b0;
        for (int k = 1; k < 4; k++) chk("b2b_interval", acc_cyc[k] - acc_cyc[k-1], 32'd3);
`ifdef ALU_ISSUE_STATS_EN
        chk("b2b_retired_cnt", {16'b0, retired_cnt}, retired_m);
`endif

        // randomized instructions against the model
        for (int r = 0; r < 60; r++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            predict(ins, md, mz, mc, me);
            do_instr(ins, $urandom_range(0, 2), md, mz, mc, me);
        end
`ifdef ALU_ISSUE_STATS_EN
        chk("rand_retired_cnt", {16'b0, retired_cnt}, retired_m);
        chk("rand_illegal_cnt", {16'b0, illegal_cnt}, illegal_m);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
